// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects
// and the multiply/divide unit busy-state encoding.
package hazard_controller_pkg;

  // Operand source chosen by the forwarding muxes in execute.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  // Multiply/divide unit occupancy.
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Address-compare forwarding selector for one source operand.
// The memory-stage path can be disabled with m_fwd_ok (decode stage cannot
// take a load result) and the writeback path disabled via w_rf_we.
module forward_unit
  import hazard_controller_pkg::*;
#(
  parameter int RF_AW = 5
) (
  input  logic [RF_AW-1:0] src,
  input  logic [RF_AW-1:0] m_rf_wa,
  input  logic             m_rf_we,
  input  logic             m_fwd_ok,
  input  logic [RF_AW-1:0] w_rf_wa,
  input  logic             w_rf_we,
  output fwd_sel_t         sel
);

  logic src_nz_s;

  assign src_nz_s = (src != {RF_AW{1'b0}});

  // Pick the youngest producer of src; register $0 is never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (src_nz_s && m_rf_we && m_fwd_ok && (src == m_rf_wa)) begin
      sel = FWD_MEM;
    end else if (src_nz_s && w_rf_we && (src == w_rf_wa)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core: stall/flush generation,
// operand forwarding selects, MDU busy tracking and stall perf counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int RF_AW       = 5,
  parameter int MDU_LATENCY = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RF_AW-1:0] d_rs,
  input  logic [RF_AW-1:0] d_rt,
  input  logic             d_branch,
  input  logic             d_mdu_use,
  input  logic [RF_AW-1:0] e_rs,
  input  logic [RF_AW-1:0] e_rt,
  input  logic [RF_AW-1:0] e_rf_wa,
  input  logic             e_rf_we,
  input  logic             e_is_load,
  input  logic             e_mdu_start,
  input  logic [RF_AW-1:0] m_rf_wa,
  input  logic             m_rf_we,
  input  logic             m_is_load,
  input  logic [RF_AW-1:0] w_rf_wa,
  input  logic             w_rf_we,
  input  logic             perf_clear,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output fwd_sel_t         fwd_a_e,
  output fwd_sel_t         fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] lu_stalls
);

  localparam logic [7:0]       MDU_LOAD = 8'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RF_AW-1:0] REG_ZERO = {RF_AW{1'b0}};

  mdu_state_t state_r;
  mdu_state_t state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;

  logic     lu_stall_s;
  logic     br_stall_s;
  logic     mdu_stall_s;
  logic     stall_s;
  logic     e_hits_d_s;
  logic     m_hits_d_s;
  fwd_sel_t sel_a_d_s;
  fwd_sel_t sel_b_d_s;

  // Execute-stage ALU operand forwarding.
  forward_unit #(.RF_AW(RF_AW)) u_fwd_a_e (
    .src(e_rs), .m_rf_wa(m_rf_wa), .m_rf_we(m_rf_we), .m_fwd_ok(1'b1),
    .w_rf_wa(w_rf_wa), .w_rf_we(w_rf_we), .sel(fwd_a_e)
  );
  forward_unit #(.RF_AW(RF_AW)) u_fwd_b_e (
    .src(e_rt), .m_rf_wa(m_rf_wa), .m_rf_we(m_rf_we), .m_fwd_ok(1'b1),
    .w_rf_wa(w_rf_wa), .w_rf_we(w_rf_we), .sel(fwd_b_e)
  );

  // Decode-stage branch compare only takes a non-load ALU result from memory.
  forward_unit #(.RF_AW(RF_AW)) u_fwd_a_d (
    .src(d_rs), .m_rf_wa(m_rf_wa), .m_rf_we(m_rf_we), .m_fwd_ok(!m_is_load),
    .w_rf_wa(w_rf_wa), .w_rf_we(1'b0), .sel(sel_a_d_s)
  );
  forward_unit #(.RF_AW(RF_AW)) u_fwd_b_d (
    .src(d_rt), .m_rf_wa(m_rf_wa), .m_rf_we(m_rf_we), .m_fwd_ok(!m_is_load),
    .w_rf_wa(w_rf_wa), .w_rf_we(1'b0), .sel(sel_b_d_s)
  );

  assign fwd_a_d = (sel_a_d_s == FWD_MEM);
  assign fwd_b_d = (sel_b_d_s == FWD_MEM);

  assign e_hits_d_s = (e_rf_wa != REG_ZERO) && ((e_rf_wa == d_rs) || (e_rf_wa == d_rt));
  assign m_hits_d_s = (m_rf_wa != REG_ZERO) && ((m_rf_wa == d_rs) || (m_rf_wa == d_rt));

  assign lu_stall_s  = e_is_load && e_rf_we && e_hits_d_s;
  assign br_stall_s  = d_branch && ((e_rf_we && e_hits_d_s) || (m_is_load && m_hits_d_s));
  assign mdu_stall_s = d_mdu_use && ((state_r == MDU_BUSY) || e_mdu_start);
  assign stall_s     = lu_stall_s || br_stall_s || mdu_stall_s;

  assign stall_f  = stall_s;
  assign stall_d  = stall_s;
  assign flush_e  = stall_s;
  assign mdu_busy = (state_r == MDU_BUSY);

  // MDU busy FSM state and countdown register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= MDU_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // MDU next state: load the latency on start, count down while busy;
  // a start seen while busy is ignored.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      MDU_IDLE: begin
        if (e_mdu_start) begin
          state_nxt_s = MDU_BUSY;
          cnt_nxt_s   = MDU_LOAD;
        end else begin
          state_nxt_s = MDU_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      end
      MDU_BUSY: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = MDU_IDLE;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = MDU_BUSY;
          cnt_nxt_s   = cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s = MDU_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Saturating stall performance counters; clear beats increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= {CNT_W{1'b0}};
      lu_stalls    <= {CNT_W{1'b0}};
    end else if (perf_clear) begin
      stall_cycles <= {CNT_W{1'b0}};
      lu_stalls    <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (lu_stall_s && (lu_stalls != CNT_MAX)) begin
        lu_stalls <= lu_stalls + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: a behavioural model checked on
// every falling edge plus directed scenarios with literal expectations.
module tb_hazard_controller;

  localparam int LAT   = 8;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic       clock;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa;
  logic       d_branch, d_mdu_use, e_rf_we, e_is_load, e_mdu_start;
  logic       m_rf_we, m_is_load, w_rf_we, perf_clear;
  logic       stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, mdu_busy;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [CW-1:0] stall_cycles, lu_stalls;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: remaining busy cycles and counter values.
  int m_busy = 0;
  int m_sc   = 0;
  int m_lu   = 0;

  hazard_controller #(.RF_AW(5), .MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_branch(d_branch), .d_mdu_use(d_mdu_use),
    .e_rs(e_rs), .e_rt(e_rt), .e_rf_wa(e_rf_wa), .e_rf_we(e_rf_we),
    .e_is_load(e_is_load), .e_mdu_start(e_mdu_start),
    .m_rf_wa(m_rf_wa), .m_rf_we(m_rf_we), .m_is_load(m_is_load),
    .w_rf_wa(w_rf_wa), .w_rf_we(w_rf_we), .perf_clear(perf_clear),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .mdu_busy(mdu_busy), .stall_cycles(stall_cycles), .lu_stalls(lu_stalls)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model rules written straight from the behaviour description.
  function automatic bit dreads(input logic [4:0] a);
    return (a != 5'd0) && ((a == d_rs) || (a == d_rt));
  endfunction

  function automatic bit m_lu_stall();
    return e_is_load && e_rf_we && dreads(e_rf_wa);
  endfunction

  function automatic bit m_stall();
    bit br, mdu;
    br  = d_branch && ((e_rf_we && dreads(e_rf_wa)) || (m_is_load && dreads(m_rf_wa)));
    mdu = d_mdu_use && ((m_busy > 0) || e_mdu_start);
    return m_lu_stall() || br || mdu;
  endfunction

  function automatic int m_fwd_e(input logic [4:0] s);
    if (s == 5'd0) return 0;
    if (m_rf_we && s == m_rf_wa) return 2;
    if (w_rf_we && s == w_rf_wa) return 1;
    return 0;
  endfunction

  function automatic int m_fwd_d(input logic [4:0] s);
    return ((s != 5'd0) && m_rf_we && !m_is_load && (s == m_rf_wa)) ? 1 : 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Model state advance on each clock edge; asynchronous reset clears it.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 0;
      m_sc   <= 0;
      m_lu   <= 0;
    end else begin
      m_sc   <= perf_clear ? 0 : (m_stall() ? sat_inc(m_sc) : m_sc);
      m_lu   <= perf_clear ? 0 : (m_lu_stall() ? sat_inc(m_lu) : m_lu);
      m_busy <= (m_busy > 0) ? m_busy - 1 : (e_mdu_start ? LAT : 0);
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clock) begin
    check("stall_f",      int'(stall_f),      int'(m_stall()));
    check("stall_d",      int'(stall_d),      int'(m_stall()));
    check("flush_e",      int'(flush_e),      int'(m_stall()));
    check("fwd_a_e",      int'(fwd_a_e),      m_fwd_e(e_rs));
    check("fwd_b_e",      int'(fwd_b_e),      m_fwd_e(e_rt));
    check("fwd_a_d",      int'(fwd_a_d),      m_fwd_d(d_rs));
    check("fwd_b_d",      int'(fwd_b_d),      m_fwd_d(d_rt));
    check("mdu_busy",     int'(mdu_busy),     (m_busy > 0) ? 1 : 0);
    check("stall_cycles", int'(stall_cycles), m_sc);
    check("lu_stalls",    int'(lu_stalls),    m_lu);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    d_rs = 5'd0; d_rt = 5'd0; d_branch = 1'b0; d_mdu_use = 1'b0;
    e_rs = 5'd0; e_rt = 5'd0; e_rf_wa = 5'd0; e_rf_we = 1'b0;
    e_is_load = 1'b0; e_mdu_start = 1'b0;
    m_rf_wa = 5'd0; m_rf_we = 1'b0; m_is_load = 1'b0;
    w_rf_wa = 5'd0; w_rf_we = 1'b0; perf_clear = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    check("rst_busy", int'(mdu_busy), 0);
    check("rst_sc",   int'(stall_cycles), 0);
    check("rst_lu",   int'(lu_stalls), 0);
    step(); step();
    reset = 1'b0;
    step();

    // 1: load-use on rs=8
    e_is_load = 1'b1; e_rf_we = 1'b1; e_rf_wa = 5'd8; d_rs = 5'd8; d_rt = 5'd3;
    #1;
    check("t1_stall", int'(stall_d), 1);
    check("t1_flush", int'(flush_e), 1);
    step();
    idle(); d_rs = 5'd8; d_rt = 5'd3; m_rf_wa = 5'd8; m_rf_we = 1'b1; m_is_load = 1'b1;
    #1;
    check("t1_nostall", int'(stall_d), 0);
    check("t1_lu_cnt",  int'(lu_stalls), 1);
    check("t1_sc_cnt",  int'(stall_cycles), 1);
    step();
    idle(); e_rs = 5'd8; e_rt = 5'd3; w_rf_wa = 5'd8; w_rf_we = 1'b1;
    #1;
    check("t1_fwd_wb", int'(fwd_a_e), 1);
    step();

    // 2: forwarding priority and $0 guard
    idle(); m_rf_wa = 5'd9; w_rf_wa = 5'd9; m_rf_we = 1'b1; w_rf_we = 1'b1;
    e_rs = 5'd9; e_rt = 5'd9; d_rs = 5'd9;
    #1;
    check("t2_mem_a", int'(fwd_a_e), 2);
    check("t2_mem_b", int'(fwd_b_e), 2);
    check("t2_d_alu", int'(fwd_a_d), 1);
    m_is_load = 1'b1;
    #1;
    check("t2_d_load", int'(fwd_a_d), 0);
    m_is_load = 1'b0; m_rf_we = 1'b0;
    #1;
    check("t2_wb", int'(fwd_a_e), 1);
    m_rf_wa = 5'd0; w_rf_wa = 5'd0; m_rf_we = 1'b1; e_rs = 5'd0;
    #1;
    check("t2_zero", int'(fwd_a_e), 0);
    step();

    // 3: branch depends on ALU result in execute, then forwards from memory
    idle(); d_branch = 1'b1; d_rs = 5'd2; d_rt = 5'd10; e_rf_wa = 5'd10; e_rf_we = 1'b1;
    #1;
    check("t3_stall", int'(stall_d), 1);
    step();
    idle(); d_branch = 1'b1; d_rs = 5'd2; d_rt = 5'd10; m_rf_wa = 5'd10; m_rf_we = 1'b1;
    #1;
    check("t3_fwd_d", int'(fwd_b_d), 1);
    check("t3_nostall", int'(stall_d), 0);
    m_is_load = 1'b1;
    #1;
    check("t3_ld_stall", int'(stall_d), 1);
    step();

    // 4: MDU occupancy stalls dependent MDU use for LAT cycles
    idle(); perf_clear = 1'b1;
    step();
    idle(); e_mdu_start = 1'b1;
    #1;
    check("t4_clr", int'(stall_cycles), 0);
    check("t4_idle", int'(mdu_busy), 0);
    step();
    idle(); d_mdu_use = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      e_mdu_start = (i == 3) ? 1'b1 : 1'b0;
      #1;
      check("t4_busy", int'(mdu_busy), 1);
      check("t4_stall", int'(stall_d), 1);
      step();
    end
    e_mdu_start = 1'b0;
    #1;
    check("t4_done", int'(mdu_busy), 0);
    check("t4_free", int'(stall_d), 0);
    check("t4_sc", int'(stall_cycles), 8);
    step();

    // 5: reset mid-BUSY
    idle(); perf_clear = 1'b1;
    step();
    idle(); e_mdu_start = 1'b1;
    step();
    idle(); d_mdu_use = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("t5_busy", int'(mdu_busy), 0);
    check("t5_stall", int'(stall_d), 0);
    check("t5_sc", int'(stall_cycles), 0);
    step();
    reset = 1'b0;
    step();
    check("t5_after", int'(stall_d), 0);
    step();

    // 6: counter saturation and clear-beats-increment
    idle(); e_is_load = 1'b1; e_rf_we = 1'b1; e_rf_wa = 5'd8; d_rs = 5'd8;
    for (int i = 0; i < 20; i++) step();
    check("t6_sat_sc", int'(stall_cycles), 15);
    check("t6_sat_lu", int'(lu_stalls), 15);
    perf_clear = 1'b1;
    step();
    idle();
    #1;
    check("t6_clr_sc", int'(stall_cycles), 0);
    check("t6_clr_lu", int'(lu_stalls), 0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
